// File: rtl/desloca_serializa.sv
// desloca_serializa: parallel-in, MSB-first serial-out shifter with valid/accept handshake; DESLOCA_SERIALIZA_PARIDADE_EN appends an even-parity bit
module desloca_serializa #(
  parameter int LARGURA = 12
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [LARGURA-1:0] Entrada,
  input  logic               Inicia,
  input  logic               Aceita,
  output logic               Pronto,
  output logic               BitSaida,
  output logic               BitValido,
  output logic               Ultimo
);
  localparam int CW = $clog2(LARGURA + 2);
`ifdef DESLOCA_SERIALIZA_PARIDADE_EN
  typedef enum logic [1:0] {OCIOSO, ENVIANDO, PARIDADE} estado_t;
  logic paridade;
`else
  typedef enum logic [0:0] {OCIOSO, ENVIANDO} estado_t;
`endif
  estado_t estado, prox;
  logic [LARGURA-1:0] desloc;
  logic [CW-1:0] cont;
  logic carga, transf, fim;
  assign carga  = estado == OCIOSO && Inicia;
  assign transf = estado == ENVIANDO && Aceita;
  assign fim    = cont == CW'(1);
  // state register
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) estado <= OCIOSO;
    else estado <= prox;
  // next state: load from idle, leave after the last data bit (or the parity bit)
  always_comb begin
    prox = estado;
    if (carga) prox = ENVIANDO;
`ifdef DESLOCA_SERIALIZA_PARIDADE_EN
    else if (transf && fim) prox = PARIDADE;
    else if (estado == PARIDADE && Aceita) prox = OCIOSO;
`else
    else if (transf && fim) prox = OCIOSO;
`endif
  end
  // shift register and bit counter: load on accepted start, shift on each transfer, hold otherwise
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      desloc <= '0;
      cont   <= '0;
    end else if (carga) begin
      desloc <= Entrada;
      cont   <= CW'(LARGURA);
    end else if (transf) begin
      desloc <= {desloc[LARGURA-2:0], 1'b0};
      cont   <= cont - CW'(1);
    end
`ifdef DESLOCA_SERIALIZA_PARIDADE_EN
  // parity captured at load so later Entrada changes cannot affect it
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) paridade <= 1'b0;
    else if (carga) paridade <= ^Entrada;
`endif
  // outputs decoded from registered state only
  always_comb begin
    Pronto    = estado == OCIOSO;
    BitValido = estado != OCIOSO;
`ifdef DESLOCA_SERIALIZA_PARIDADE_EN
    BitSaida  = estado == ENVIANDO ? desloc[LARGURA-1] : estado == PARIDADE && paridade;
    Ultimo    = estado == PARIDADE;
`else
    BitSaida  = estado == ENVIANDO && desloc[LARGURA-1];
    Ultimo    = estado == ENVIANDO && fim;
`endif
  end
endmodule

// File: tb/tb_desloca_serializa.sv
// tb_desloca_serializa: vector table, corner sequences and random traffic against a bit-queue reference model
module tb_desloca_serializa;
`ifdef DESLOCA_SERIALIZA_PARIDADE_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic Clock = 1'b0, Reset_n = 1'b0, Inicia = 1'b0, Aceita = 1'b0;
  logic [11:0] Entrada = '0;
  logic Pronto, BitSaida, BitValido, Ultimo;
  int compared = 0, mismatched = 0;
  bit q[$];

  desloca_serializa #(.LARGURA(12)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Entrada(Entrada), .Inicia(Inicia),
    .Aceita(Aceita), .Pronto(Pronto), .BitSaida(BitSaida),
    .BitValido(BitValido), .Ultimo(Ultimo)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [11:0] entrada;
    logic [11:0] bits;
    logic        par;
  } vec_t;

  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".pronto"}, Pronto, q.size() == 0);
    chk({nm, ".valido"}, BitValido, q.size() != 0);
    chk({nm, ".bit"}, BitSaida, q.size() != 0 ? q[0] : 1'b0);
    chk({nm, ".ultimo"}, Ultimo, q.size() == 1);
  endtask

  task automatic tick(input string nm);
    @(posedge Clock);
    if (!Reset_n) q.delete();
    else if (q.size() == 0 && Inicia) begin
      for (int i = 11; i >= 0; i--) q.push_back(Entrada[i]);
      if (PAR) q.push_back(^Entrada);
    end else if (q.size() != 0 && Aceita) void'(q.pop_front());
    #1;
    chk_model(nm);
  endtask

  task automatic load(input logic [11:0] w, input logic a);
    Entrada = w;
    Inicia = 1'b1;
    Aceita = a;
    tick("load");
    Inicia = 1'b0;
    Entrada = $urandom;
  endtask

  vec_t tab[5];
  logic [11:0] w;

  initial begin
    tab[0] = '{12'hA5C, 12'b101001011100, 1'b0};
    tab[1] = '{12'h007, 12'b000000000111, 1'b1};
    tab[2] = '{12'h003, 12'b000000000011, 1'b0};
    tab[3] = '{12'hFFF, 12'b111111111111, 1'b0};
    tab[4] = '{12'h6B1, 12'b011010110001, 1'b0};

    for (int i = 0; i < 5; i++) begin
      Inicia = 1'($urandom);
      Aceita = 1'($urandom);
      Entrada = $urandom;
      tick("reset_hold");
      chk("reset_pronto", Pronto, 1);
      chk("reset_valido", BitValido, 0);
      chk("reset_bit", BitSaida, 0);
      chk("reset_ultimo", Ultimo, 0);
    end
    Inicia = 1'b0;
    Reset_n = 1'b1;
    tick("idle");

    foreach (tab[k]) begin
      load(tab[k].entrada, 1'b1);
      for (int i = 0; i < 12; i++) begin
        chk("vec_bit", BitSaida, tab[k].bits[11-i]);
        chk("vec_ultimo", Ultimo, !PAR && i == 11);
        tick("vec_shift");
      end
      if (PAR) begin
        chk("vec_par", BitSaida, tab[k].par);
        chk("vec_par_ultimo", Ultimo, 1);
        tick("vec_par_shift");
      end
      chk("vec_pronto", Pronto, 1);
    end

    load(12'h800, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", BitSaida, 1);
      tick("bp_stall");
    end
    Aceita = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("bp_bit", BitSaida, i == 0);
      chk("bp_valido", BitValido, 1);
      tick("bp_shift");
    end
    if (PAR) tick("bp_par");
    chk("bp_pronto", Pronto, 1);

    load(12'h0F0, 1'b1);
    w = '0;
    for (int i = 0; i < 12 + int'(PAR); i++) begin
      if (i < 12) w = {w[10:0], BitSaida};
      Inicia = i == 4 || i == 11 + int'(PAR);
      Entrada = 12'hFFF;
      tick("busy_shift");
    end
    Inicia = 1'b0;
    chk("busy_word", w, 12'h0F0);
    chk("busy_pronto", Pronto, 1);
    tick("busy_idle");
    chk("busy_stays_idle", Pronto, 1);

    load(12'hFFF, 1'b1);
    for (int i = 0; i < 5; i++) tick("rst_pre");
    Reset_n = 1'b0;
    q.delete();
    #1 chk_model("rst_async");
    tick("rst_low");
    #2 Reset_n = 1'b1;
    load(12'h001, 1'b1);
    w = '0;
    for (int i = 0; i < 12; i++) begin
      w = {w[10:0], BitSaida};
      tick("rst_shift");
    end
    chk("rst_word", w, 12'h001);
    if (PAR) begin
      chk("rst_par", BitSaida, 1);
      tick("rst_par_shift");
    end
    chk("rst_pronto", Pronto, 1);

    for (int n = 0; n < 3000; n++) begin
      Inicia = $urandom_range(0, 2) == 0;
      Aceita = $urandom_range(0, 9) < 7;
      Entrada = $urandom;
      Reset_n = $urandom_range(0, 199) != 0;
      if (!Reset_n) begin
        q.delete();
        #1 chk_model("rnd_async");
      end
      tick("rnd");
      Reset_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/desloca_serializa.md
# desloca_serializa

Parallel-in, serial-out shifter that takes a 12-bit word and emits it MSB-first, one bit per accepted transfer, under a valid/accept handshake. It is the transmit-side counterpart of the datapath's shift-left-and-insert-LSB stage: that stage builds a word by shifting bits in at the LSB, and this block takes a word apart by shifting bits out at the MSB. It sits between the arithmetic result register and any bit-serial consumer (serial link, LED shifter, bit-serial divider input).

## Interface
- `LARGURA`, default 12: word width in bits. The bit counter is ceil(log2(LARGURA+2)) bits wide.
- `Clock` input 1: single clock. All registers update on the rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Entrada` input LARGURA: parallel word. Sampled only on a cycle where `Inicia`=1 and `Pronto`=1.
- `Inicia` input 1: load request.
- `Pronto` output 1: block is idle and will accept `Inicia`.
- `BitSaida` output 1: current serial bit, the MSB of the shift register.
- `BitValido` output 1: `BitSaida` is valid.
- `Aceita` input 1: consumer takes the bit. A transfer occurs on an edge where `BitValido`=1 and `Aceita`=1.
- `Ultimo` output 1: the bit currently presented is the final bit of the word.

## Operation
- FSM states: OCIOSO, ENVIANDO, and PARIDADE (PARIDADE exists only with the macro).
- **OCIOSO**
  - `Pronto`=1, `BitValido`=0, `BitSaida`=0, `Ultimo`=0.
  - On `Inicia`=1: the shift register loads `Entrada`, the counter loads LARGURA, and the FSM goes to ENVIANDO.
- **ENVIANDO**
  - Outputs: `BitValido`=1, `BitSaida`=reg[LARGURA-1], `Pronto`=0.
  - On each transfer: reg <= {reg[LARGURA-2:0],1'b0} and the counter decrements. The shifted-out MSB is discarded.
  - With no transfer, the register and counter hold. The bit stays stable under backpressure.
  - `Ultimo`=1 when counter==1 and the macro is absent.
  - On the transfer with counter==1: go to PARIDADE if the macro is present, otherwise go to OCIOSO.
- **PARIDADE**
  - `BitSaida`=stored parity bit, `BitValido`=1, `Ultimo`=1.
  - On a transfer: go to OCIOSO.
- Boundary conditions:
  - `Inicia` while `Pronto`=0 is ignored. `Entrada` is not sampled and the in-flight word is unaffected.
  - `Inicia` on the same edge as the final transfer is ignored, because `Pronto` is still 0 on that cycle.
  - `Aceita` while `BitValido`=0 has no effect.
  - An `Entrada` change after load has no effect.
  - `Reset_n` low at any time, including mid-word, immediately forces OCIOSO with all outputs at reset values. The partial word is dropped and no residue survives into the next word.

## Timing
- Reset values: `Pronto`=1, `BitValido`=0, `BitSaida`=0, `Ultimo`=0, shift register=0, counter=0, parity=0.
- All outputs are registered-state decodes, with no combinational path from inputs.
- Load latency: with `Inicia` accepted at edge N, `BitValido`=1 and `BitSaida`=Entrada[LARGURA-1] from edge N up to edge N+1.
- Throughput: with `Aceita` held at 1, one bit per cycle. A word takes LARGURA cycles (LARGURA+1 with the macro).
- `Pronto` returns to 1 on the cycle after the final transfer. The minimum spacing between word starts is LARGURA+1 cycles (LARGURA+2 with the macro).

## Configuration
- Macro: `DESLOCA_SERIALIZA_PARIDADE_EN`.
- Defined:
  - Parity = XOR of `Entrada` is computed and stored at load.
  - That parity bit is sent as an extra bit after bit 0. The total across the word plus the parity bit is an even count of ones.
  - `Ultimo` marks the parity bit, not bit 0.
- Undefined:
  - No PARIDADE state and no parity register.
  - Exactly LARGURA bits per word, and `Ultimo` marks bit 0.

## Test plan
- **Reset:** hold `Reset_n`=0 with random inputs → `Pronto`=1, `BitValido`=0, `BitSaida`=0, `Ultimo`=0 throughout.
- **Basic word:** load 12'hA5C, `Aceita`=1 constant →
  - `BitSaida` sequence 1,0,1,0,0,1,0,1,1,1,0,0 on 12 consecutive cycles.
  - `Ultimo` high only on the 12th bit.
  - `Pronto`=1 on the next cycle.
- **Backpressure:** load 12'h800, `Aceita`=0 for 3 cycles then 1 → `BitSaida`=1 held stable for 4 cycles, then 11 zeros. Total 12 transfers.
- **Busy load:** load 12'h0F0, pulse `Inicia` with `Entrada`=12'hFFF on bit 4 and again on the final-transfer edge → output remains 12'h0F0 exactly, and `Pronto` returns one cycle later.
- **Reset mid-word:** load 12'hFFF, assert `Reset_n`=0 after 5 transfers, release, then load 12'h001 → 11 zeros then 1, with no leftover ones.
- **Parity (macro on):** load 12'h007 → 12 data bits, then a 13th bit = 1 with `Ultimo`. Load 12'h003 → 13th bit = 0. With the macro off, the same stimulus yields 12 bits and `Ultimo` on bit 0.
